// File: rtl/rsa_stream_wrapper.sv
// rtl/rsa_stream_wrapper.sv - byte-stream front/back end for Rsa256Core
// Loads N and E once, then repeatedly captures a block A, runs the core, and streams 31 result bytes out.
module rsa_stream_wrapper #(
  parameter int KEY_BYTES = 32,
  parameter int OUT_BYTES = 31
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [7:0]   i_byte,
  input  logic         i_byte_valid,
  output logic         o_byte_ready,
  output logic [7:0]   o_byte,
  output logic         o_byte_valid,
  input  logic         i_byte_ready,
  output logic [255:0] o_core_n,
  output logic [255:0] o_core_e,
  output logic [255:0] o_core_a,
  output logic         o_core_start,
  input  logic [255:0] i_core_a_pow_e,
  input  logic         i_core_finished,
  output logic         o_key_loaded
);

  typedef enum logic [2:0] {
    S_GET_N,
    S_GET_E,
    S_GET_A,
    S_START,
    S_WAIT,
    S_SEND
  } state_t;

  localparam logic [4:0] LAST_IN  = 5'(KEY_BYTES - 1);
  localparam logic [4:0] LAST_OUT = 5'(OUT_BYTES - 1);

  state_t       state;
  logic [4:0]   cnt;
  logic [247:0] out_sr;
  logic         in_xfer;
  logic         out_xfer;
  logic         unused_top;

  assign in_xfer    = i_byte_valid & o_byte_ready;
  assign out_xfer   = o_byte_valid & i_byte_ready;
  assign o_byte     = out_sr[247:240];
  // The top result byte is never transmitted.
  assign unused_top = ^i_core_a_pow_e[255:248];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_GET_N;
      cnt          <= 5'd0;
      out_sr       <= '0;
      o_core_n     <= '0;
      o_core_e     <= '0;
      o_core_a     <= '0;
      o_core_start <= 1'b0;
      o_byte_ready <= 1'b0;
      o_byte_valid <= 1'b0;
      o_key_loaded <= 1'b0;
    end else begin
      o_core_start <= 1'b0;
      case (state)
        S_GET_N: begin
          o_byte_ready <= 1'b1;
          if (in_xfer) begin
            o_core_n <= {o_core_n[247:0], i_byte};
            if (cnt == LAST_IN) begin
              cnt   <= 5'd0;
              state <= S_GET_E;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        S_GET_E: begin
          o_byte_ready <= 1'b1;
          if (in_xfer) begin
            o_core_e <= {o_core_e[247:0], i_byte};
            if (cnt == LAST_IN) begin
              cnt          <= 5'd0;
              o_key_loaded <= 1'b1;
              state        <= S_GET_A;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        S_GET_A: begin
          o_byte_ready <= 1'b1;
          if (in_xfer) begin
            o_core_a <= {o_core_a[247:0], i_byte};
            if (cnt == LAST_IN) begin
              cnt          <= 5'd0;
              o_byte_ready <= 1'b0;
              o_core_start <= 1'b1;
              state        <= S_START;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        S_START: begin
          state <= S_WAIT;
        end
        // finished is only honoured here, so a pulse coinciding with start is dropped.
        S_WAIT: begin
          if (i_core_finished) begin
            out_sr       <= i_core_a_pow_e[247:0];
            o_byte_valid <= 1'b1;
            state        <= S_SEND;
          end
        end
        S_SEND: begin
          if (out_xfer) begin
            out_sr <= {out_sr[239:0], 8'h00};
            if (cnt == LAST_OUT) begin
              cnt          <= 5'd0;
              o_byte_valid <= 1'b0;
              o_byte_ready <= 1'b1;
              state        <= S_GET_A;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        default: begin
          state        <= S_GET_N;
          cnt          <= 5'd0;
          o_byte_ready <= 1'b0;
          o_byte_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_stream_wrapper.sv
// tb/tb_rsa_stream_wrapper.sv - directed self-checking bench for rsa_stream_wrapper
module tb_rsa_stream_wrapper;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   i_byte;
  logic         i_byte_valid;
  logic         o_byte_ready;
  logic [7:0]   o_byte;
  logic         o_byte_valid;
  logic         i_byte_ready;
  logic [255:0] o_core_n;
  logic [255:0] o_core_e;
  logic [255:0] o_core_a;
  logic         o_core_start;
  logic [255:0] core_res;
  logic         core_finished;
  logic         o_key_loaded;

  int checks   = 0;
  int failures = 0;

  logic [255:0] key_n;
  logic [255:0] key_e;
  logic [255:0] res1;
  logic [255:0] res2;
  logic [255:0] res3;

  always #5 clk = ~clk;

  rsa_stream_wrapper dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_byte         (i_byte),
    .i_byte_valid   (i_byte_valid),
    .o_byte_ready   (o_byte_ready),
    .o_byte         (o_byte),
    .o_byte_valid   (o_byte_valid),
    .i_byte_ready   (i_byte_ready),
    .o_core_n       (o_core_n),
    .o_core_e       (o_core_e),
    .o_core_a       (o_core_a),
    .o_core_start   (o_core_start),
    .i_core_a_pow_e (core_res),
    .i_core_finished(core_finished),
    .o_key_loaded   (o_key_loaded)
  );

  task automatic send_byte(input logic [7:0] b);
    int waits;
    waits        = 0;
    i_byte       = b;
    i_byte_valid = 1'b1;
    @(negedge clk);
    while (!o_byte_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    checks++;
    if (o_byte_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready: o_byte_ready=%b required 1", o_byte_ready);
    end
    @(posedge clk);
    #1;
    i_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [255:0] w, input int max_gap);
    for (int i = 0; i < 32; i++) begin
      send_byte(w[255-8*i -: 8]);
      if (max_gap > 0 && i < 31) begin
        repeat ($urandom_range(max_gap, 0)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  // Called right after the 32nd A byte; emulates the core answering with res.
  task automatic run_core(input logic [255:0] res, input logic early_finish);
    @(negedge clk);
    checks++;
    if (o_core_start !== 1'b1) begin
      failures++;
      $display("FAIL start_pulse: o_core_start=%b required 1", o_core_start);
    end
    if (early_finish) begin
      core_res      = ~res;
      core_finished = 1'b1;
    end
    @(posedge clk);
    #1;
    core_finished = 1'b0;
    @(negedge clk);
    checks++;
    if (o_core_start !== 1'b0 || o_byte_valid !== 1'b0 || o_byte_ready !== 1'b0) begin
      failures++;
      $display("FAIL wait_state: start=%b valid=%b ready=%b required 0 0 0", o_core_start, o_byte_valid, o_byte_ready);
    end
    if (early_finish) begin
      repeat (3) @(negedge clk);
      checks++;
      if (o_byte_valid !== 1'b0) begin
        failures++;
        $display("FAIL early_finish_ignored: o_byte_valid=%b required 0", o_byte_valid);
      end
    end
    @(posedge clk);
    #1;
    core_res      = res;
    core_finished = 1'b1;
    @(posedge clk);
    #1;
    core_finished = 1'b0;
    core_res      = '0;
    checks++;
    if (o_byte_valid !== 1'b1) begin
      failures++;
      $display("FAIL first_valid: o_byte_valid=%b required 1", o_byte_valid);
    end
  endtask

  // mode 0: always ready; mode 1: toggling ready with a 10-cycle stall at byte 15.
  task automatic recv_result(input logic [247:0] exp, input int mode);
    int   got;
    int   cyc;
    int   stall;
    logic r;
    got   = 0;
    cyc   = 0;
    stall = 0;
    while (got < 31 && cyc < 400) begin
      if (mode == 0) r = 1'b1;
      else if (got == 15 && stall < 10) begin
        r = 1'b0;
        stall++;
      end else r = cyc[0];
      i_byte_ready = r;
      @(negedge clk);
      checks++;
      if (o_byte_valid !== 1'b1 || o_byte !== exp[247-8*got -: 8]) begin
        failures++;
        $display("FAIL out_byte[%0d]: o_byte=%h valid=%b required %h valid 1", got, o_byte, o_byte_valid, exp[247-8*got -: 8]);
      end
      if (r && o_byte_valid) got++;
      @(posedge clk);
      #1;
      cyc++;
    end
    i_byte_ready = 1'b0;
    checks++;
    if (got != 31) begin
      failures++;
      $display("FAIL out_count: got=%0d required 31", got);
    end
    checks++;
    if (o_byte_valid !== 1'b0 || o_byte_ready !== 1'b1) begin
      failures++;
      $display("FAIL after_send: valid=%b ready=%b required 0 1", o_byte_valid, o_byte_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    checks++;
    if (o_byte_ready !== 1'b0 || o_byte_valid !== 1'b0 || o_byte !== 8'h00 || o_core_start !== 1'b0 ||
        o_key_loaded !== 1'b0 || o_core_n !== '0 || o_core_e !== '0 || o_core_a !== '0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b valid=%b byte=%h start=%b key=%b required all 0",
               o_byte_ready, o_byte_valid, o_byte, o_core_start, o_key_loaded);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (o_byte_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset: o_byte_ready=%b required 1", o_byte_ready);
    end
  endtask

  task automatic test_key_load(input int max_gap);
    send_word(key_n, max_gap);
    checks++;
    if (o_core_n !== key_n || o_key_loaded !== 1'b0) begin
      failures++;
      $display("FAIL n_load: o_core_n=%h key_loaded=%b required %h 0", o_core_n, o_key_loaded, key_n);
    end
    send_word(key_e, max_gap);
    checks++;
    if (o_core_e !== key_e || o_key_loaded !== 1'b1) begin
      failures++;
      $display("FAIL e_load: o_core_e=%h key_loaded=%b required %h 1", o_core_e, o_key_loaded, key_e);
    end
  endtask

  task automatic test_full_block(input logic [255:0] a, input logic [255:0] res, input int max_gap,
                                 input int mode, input logic early);
    send_word(a, max_gap);
    checks++;
    if (o_core_a !== a) begin
      failures++;
      $display("FAIL a_load: o_core_a=%h required %h", o_core_a, a);
    end
    run_core(res, early);
    recv_result(res[247:0], mode);
    checks++;
    if (o_core_n !== key_n || o_core_e !== key_e || o_core_a !== a) begin
      failures++;
      $display("FAIL words_hold: n=%h e=%h a=%h", o_core_n, o_core_e, o_core_a);
    end
  endtask

  task automatic test_mid_reset;
    for (int i = 0; i < 10; i++) send_byte(8'h5A);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (o_byte_ready !== 1'b0 || o_key_loaded !== 1'b0 || o_core_n !== '0 || o_core_e !== '0 || o_core_a !== '0) begin
      failures++;
      $display("FAIL mid_reset: ready=%b key=%b n=%h a=%h required all 0", o_byte_ready, o_key_loaded, o_core_n, o_core_a);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_word(key_n, 0);
    checks++;
    if (o_core_n !== key_n || o_core_e !== '0 || o_key_loaded !== 1'b0) begin
      failures++;
      $display("FAIL reload_n: o_core_n=%h key=%b required %h 0", o_core_n, o_key_loaded, key_n);
    end
  endtask

  task automatic test_input_gaps;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    test_key_load(5);
    test_full_block({32{8'h11}}, res1, 5, 0, 1'b0);
  endtask

  task automatic test_back_to_back;
    core_res      = ~res3;
    core_finished = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (o_byte_valid !== 1'b0 || o_byte_ready !== 1'b1) begin
      failures++;
      $display("FAIL spurious_finish: valid=%b ready=%b required 0 1", o_byte_valid, o_byte_ready);
    end
    @(posedge clk);
    #1;
    core_finished = 1'b0;
    core_res      = '0;
    test_full_block({32{8'h33}}, res3, 0, 0, 1'b1);
    test_full_block({16{8'h01, 8'hFE}}, res1, 0, 1, 1'b0);
  endtask

  initial begin
    rst           = 1'b1;
    i_byte        = 8'h00;
    i_byte_valid  = 1'b0;
    i_byte_ready  = 1'b0;
    core_res      = '0;
    core_finished = 1'b0;
    for (int i = 0; i < 32; i++) key_n[255-8*i -: 8] = 8'(i);
    key_e = 256'h3;
    res1  = {{31{8'hAA}}, 8'hBB};
    for (int k = 0; k < 31; k++) res2[247-8*k -: 8] = 8'(k * 7 + 3);
    res2[255:248] = 8'hEE;
    for (int k = 0; k < 31; k++) res3[247-8*k -: 8] = 8'(8'hF0 - k);
    res3[255:248] = 8'h77;

    test_reset;
    test_key_load(0);
    test_full_block({32{8'h11}}, res1, 0, 0, 1'b0);
    test_full_block({32{8'h22}}, res2, 0, 1, 1'b0);
    test_mid_reset;
    test_input_gaps;
    test_back_to_back;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
